// File: rtl/uart_host_seq_if.sv
// Bundles the client-side tx/rx byte streams and the UART core CPU port used by the host sequencer.
interface uart_host_seq_if #(
    parameter int ERR_CNT_W = 16
);
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_ovf;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 uart_csn;
    logic                 uart_wen;
    logic                 uart_oen;
    logic [7:0]           uart_din;
    logic [7:0]           uart_dout;
    logic                 uart_txrdy;
    logic                 uart_rxrdy;
    logic                 uart_perr;
    logic                 uart_ferr;
    logic                 uart_ovf;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        input  uart_dout, uart_txrdy, uart_rxrdy, uart_perr, uart_ferr, uart_ovf,
        output tx_ready, rx_data, rx_valid, rx_perr, rx_ferr, rx_ovf, err_cnt,
        output uart_csn, uart_wen, uart_oen, uart_din
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        output uart_dout, uart_txrdy, uart_rxrdy, uart_perr, uart_ferr, uart_ovf,
        input  tx_ready, rx_data, rx_valid, rx_perr, rx_ferr, rx_ovf, err_cnt,
        input  uart_csn, uart_wen, uart_oen, uart_din
    );
endinterface

// File: rtl/uart_host_seq.sv
// Sequencer that turns a tx byte stream into UART core write strobes and polls the core for
// received bytes, presenting them with their error flags on an rx stream.
module uart_host_seq #(
    parameter int HOLDOFF   = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic           CLK,
    input  logic           RESET,
    uart_host_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR_STB, RD_STB, WAIT} state_e;

    localparam logic [3:0] HoldoffInit = 4'(HOLDOFF);

    state_e               state_q;
    logic                 lastRd_q;
    logic [3:0]           cnt_q;
    logic                 txFull_q;
    logic [7:0]           txBuf_q;
    logic                 rxValid_q;
    logic [7:0]           rxData_q;
    logic                 rxPerr_q;
    logic                 rxFerr_q;
    logic                 rxOvf_q;
    logic [ERR_CNT_W-1:0] errCnt_q;
    logic [ERR_CNT_W-1:0] errCnt_d;
    logic                 csn_q;
    logic                 wen_q;
    logic                 oen_q;
    logic [7:0]           din_q;

    logic txReady;
    logic wrOk;
    logic rdOk;
    logic grantWr;
    logic anyErr;

    assign txReady = !txFull_q && !RESET;
    assign wrOk    = txFull_q && bus.uart_txrdy;
    // Only the registered rx_valid gates a read, so a byte being consumed this cycle still blocks it.
    assign rdOk    = bus.uart_rxrdy && !rxValid_q;
    assign grantWr = wrOk && (!rdOk || lastRd_q);
    assign anyErr  = bus.uart_perr || bus.uart_ferr || bus.uart_ovf;
    assign errCnt_d = (&errCnt_q) ? errCnt_q
                                  : errCnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            lastRd_q  <= 1'b1;
            cnt_q     <= 4'd0;
            txFull_q  <= 1'b0;
            txBuf_q   <= 8'd0;
            rxValid_q <= 1'b0;
            rxData_q  <= 8'd0;
            rxPerr_q  <= 1'b0;
            rxFerr_q  <= 1'b0;
            rxOvf_q   <= 1'b0;
            errCnt_q  <= '0;
            csn_q     <= 1'b1;
            wen_q     <= 1'b1;
            oen_q     <= 1'b1;
            din_q     <= 8'd0;
        end else begin
            if (bus.tx_valid && txReady) begin
                txBuf_q  <= bus.tx_data;
                txFull_q <= 1'b1;
            end
            if (rxValid_q && bus.rx_ready) begin
                rxValid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (grantWr) begin
                        state_q  <= WR_STB;
                        lastRd_q <= 1'b0;
                        csn_q    <= 1'b0;
                        wen_q    <= 1'b0;
                        din_q    <= txBuf_q;
                    end else if (rdOk) begin
                        state_q  <= RD_STB;
                        lastRd_q <= 1'b1;
                        csn_q    <= 1'b0;
                        oen_q    <= 1'b0;
                    end
                end
                WR_STB: begin
                    state_q  <= WAIT;
                    csn_q    <= 1'b1;
                    wen_q    <= 1'b1;
                    txFull_q <= 1'b0;
                    cnt_q    <= HoldoffInit;
                end
                RD_STB: begin
                    state_q   <= WAIT;
                    csn_q     <= 1'b1;
                    oen_q     <= 1'b1;
                    rxData_q  <= bus.uart_dout;
                    rxPerr_q  <= bus.uart_perr;
                    rxFerr_q  <= bus.uart_ferr;
                    rxOvf_q   <= bus.uart_ovf;
                    rxValid_q <= 1'b1;
                    cnt_q     <= HoldoffInit;
                    if (anyErr) begin
                        errCnt_q <= errCnt_d;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready = txReady;
    assign bus.rx_data  = rxData_q;
    assign bus.rx_valid = rxValid_q;
    assign bus.rx_perr  = rxPerr_q;
    assign bus.rx_ferr  = rxFerr_q;
    assign bus.rx_ovf   = rxOvf_q;
    assign bus.err_cnt  = errCnt_q;
    assign bus.uart_csn = csn_q;
    assign bus.uart_wen = wen_q;
    assign bus.uart_oen = oen_q;
    assign bus.uart_din = din_q;
endmodule
